pxbf_scanout_reader: RTL and testbench
======================================

# pxbf_scanout_reader

Avalon-MM read master that scans the pixel-buffer on-chip memory (32768 x 16, single port, fixed read latency 1, no waitrequest) sequentially, frame after frame. It pushes the words into a small internal FIFO and presents them as an Avalon-ST pixel stream with start/end-of-frame markers. It sits between the pixel-buffer memory and the VGA timing/colour path.

## Interface
Parameters:
- ADDR_W, 15: memory word-address width.
- DATA_W, 16: pixel word width.
- BASE_ADDR, 0: first word address of the frame.
- FRAME_WORDS, 19200: words per frame (160x120). Legal range 2..2^ADDR_W-BASE_ADDR.
- FIFO_DEPTH, 8: output FIFO entries. Power of two, ≥4.

Ports:
- clk, in, 1: single clock.
- reset, in, 1: asynchronous, active-high.
- enable, in, 1: run request, sampled at frame boundaries.
- m_address, out, ADDR_W: word address to memory.
- m_chipselect, out, 1: equals m_read.
- m_read, out, 1: read strobe, one word per cycle asserted.
- m_byteenable, out, 2: constant 2'b11.
- m_readdata, in, DATA_W: memory data, valid the cycle after m_read.
- st_data, out, DATA_W: pixel word.
- st_valid, out, 1: st_data valid.
- st_ready, in, 1: sink accepts when st_valid & st_ready.
- st_sop, out, 1: word is address BASE_ADDR.
- st_eop, out, 1: word is address BASE_ADDR+FRAME_WORDS-1.
- frame_done, out, 1: one-cycle pulse when the eop word is accepted.

## Operation
- States: IDLE, FETCH, FLUSH.
- IDLE: no reads are issued. If enable=1, go to FETCH with m_address=BASE_ADDR.
- FETCH: issue a read in any cycle where fifo_count + inflight < FIFO_DEPTH. inflight is the 1-bit flag "read issued last cycle". Each issued read post-increments m_address.
  - Issuing the last word (BASE_ADDR+FRAME_WORDS-1): wrap m_address to BASE_ADDR. If enable=1, stay in FETCH; else go to FLUSH.
- FLUSH: no reads. Go to IDLE when inflight=0 and the FIFO is empty.
- enable only takes effect at frame boundaries. Deasserting it mid-frame always completes the current frame.
- Returning data is written into the FIFO the cycle after issue, together with sop/eop tags derived from the issued address. The FIFO entry is DATA_W+2 bits.
- FIFO is show-ahead: st_data, st_sop and st_eop reflect the head entry whenever st_valid=1.
- A simultaneous push and pop leaves fifo_count unchanged. A pop in the same cycle does not create issue credit.
- Overflow is impossible by construction. An assertion checks that fifo_count never exceeds FIFO_DEPTH.
- The block never writes the memory.

## Timing
- Reset values: state=IDLE, m_address=BASE_ADDR, m_read=m_chipselect=0, st_valid=st_sop=st_eop=0, frame_done=0, FIFO empty, inflight=0.
- Startup sequence from IDLE:
  - Cycle 0: enable=1 seen at the clock edge.
  - Cycle 1: m_read=1, m_address=BASE_ADDR.
  - Cycle 2: m_readdata captured.
  - Cycle 3: st_valid=1 with st_sop=1.
- Throughput: with st_ready held at 1, one word per cycle is sustained, with no gap across frame wrap.
- Back-pressure: when st_ready=0, reads stop within 1 cycle once credit is exhausted. They resume the cycle after a pop restores credit.
- frame_done is registered and asserts the cycle after the eop handshake.
- Reset mid-frame: everything clears immediately. Any in-flight read data is dropped. After reset, the next frame starts at BASE_ADDR with sop.

## Structure
- Package pxbf_pkg holds:
  - The state enum (IDLE, FETCH, FLUSH).
  - The FIFO entry layout constants (SOP bit DATA_W, EOP bit DATA_W+1).
  - The default ADDR_W/DATA_W.
- Sub-module pxbf_sync_fifo: single-clock, show-ahead, parameterised width and depth, with a count output and async active-high reset.

## Test plan
- FRAME_WORDS=4, BASE_ADDR=0x10, memory model holds data=address, enable=1, st_ready=1. Required: m_read in cycles 1–4 at 0x10..0x13; st_data 0x10,0x11,0x12,0x13,0x10…; sop on 0x10, eop on 0x13; frame_done one cycle after each 0x13 is accepted.
- st_ready=0 from cycle 0 with FIFO_DEPTH=8. Required: exactly 8 reads issued, then m_read=0. After st_ready=1, every word is delivered in order with none lost.
- enable dropped after the 2nd word of a 4-word frame. Required: words 3 and 4 are still read and delivered; state returns to IDLE with no further m_read.
- reset pulsed while words are in the FIFO and a read is in flight. Required: all outputs at reset values in the same cycle; after release with enable=1, the first st_data is BASE_ADDR with st_sop=1.
- Random st_ready (50%) over 3 frames of FRAME_WORDS=19200. Required: scoreboard matches the address sequence, exactly 3 frame_done pulses, and the FIFO never overflows.

Source files
------------

// File: rtl/pxbf_pkg.sv
// Shared types and constants for the pixel-buffer scan-out reader.
// FIFO entries carry the pixel word plus its start/end-of-frame tags above it.
package pxbf_pkg;

    localparam int DEFAULT_ADDR_W = 15;
    localparam int DEFAULT_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        FLUSH
    } pxbf_state_t;

    function automatic int sopBit(input int dataW);
        return dataW;
    endfunction

    function automatic int eopBit(input int dataW);
        return dataW + 1;
    endfunction

    function automatic int entryWidth(input int dataW);
        return dataW + 2;
    endfunction

endpackage

// File: rtl/pxbf_sync_fifo.sv
// Single-clock show-ahead FIFO: o_data always shows the head entry while o_valid is high.
module pxbf_sync_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic [PTR_W:0]   o_count
);

    localparam logic [PTR_W-1:0] PTR_ONE = 1;
    localparam logic [PTR_W:0]   CNT_ONE = 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [PTR_W:0]   r_count;
    logic             w_pop;

    assign w_pop = i_pop && (r_count != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_wrPtr <= r_wrPtr + PTR_ONE;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_ONE;
            end
            if (i_push && !w_pop) begin
                r_count <= r_count + CNT_ONE;
            end else if (w_pop && !i_push) begin
                r_count <= r_count - CNT_ONE;
            end
        end
    end

    // Storage is not reset; entries are only observed once the count says they hold data.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

    assign o_data  = r_mem[r_rdPtr];
    assign o_valid = (r_count != '0);
    assign o_count = r_count;

endmodule

// File: rtl/pxbf_scanout_reader.sv
// Sequential frame scanner: reads the pixel buffer word by word and streams it out
// with sop/eop markers, throttling reads so the output FIFO can never overflow.
module pxbf_scanout_reader
    import pxbf_pkg::*;
#(
    parameter int ADDR_W      = DEFAULT_ADDR_W,
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int BASE_ADDR   = 0,
    parameter int FRAME_WORDS = 19200,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_chipselect,
    output logic              m_read,
    output logic [1:0]        m_byteenable,
    input  logic [DATA_W-1:0] m_readdata,
    output logic [DATA_W-1:0] st_data,
    output logic              st_valid,
    input  logic              st_ready,
    output logic              st_sop,
    output logic              st_eop,
    output logic              frame_done
);

    localparam int ENTRY_W = entryWidth(DATA_W);
    localparam int SOP_BIT = sopBit(DATA_W);
    localparam int EOP_BIT = eopBit(DATA_W);
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

    localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(BASE_ADDR + FRAME_WORDS - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE   = 1;

    pxbf_state_t        r_state;
    pxbf_state_t        w_nextState;
    logic [ADDR_W-1:0]  r_address;
    logic               r_inflight;
    logic               r_inflightSop;
    logic               r_inflightEop;
    logic               r_frameDone;
    logic               w_issue;
    logic               w_credit;
    logic               w_pop;
    logic               w_fifoValid;
    logic [CNT_W-1:0]   w_fifoCount;
    logic [ENTRY_W-1:0] w_head;

    // A read in flight already owns a FIFO slot, so it counts against the credit.
    assign w_credit = (w_fifoCount + CNT_W'(r_inflight)) < CNT_W'(FIFO_DEPTH);

    always_comb begin
        w_nextState = r_state;
        w_issue     = 1'b0;
        case (r_state)
            IDLE: begin
                if (enable) begin
                    w_nextState = FETCH;
                end
            end
            FETCH: begin
                w_issue = w_credit;
                if (w_issue && (r_address == LAST_ADDR) && !enable) begin
                    w_nextState = FLUSH;
                end
            end
            FLUSH: begin
                if (!r_inflight && !w_fifoValid) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_address     <= FIRST_ADDR;
            r_inflight    <= 1'b0;
            r_inflightSop <= 1'b0;
            r_inflightEop <= 1'b0;
            r_frameDone   <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_inflight  <= w_issue;
            r_frameDone <= w_pop && w_head[EOP_BIT];
            if (w_issue) begin
                r_inflightSop <= (r_address == FIRST_ADDR);
                r_inflightEop <= (r_address == LAST_ADDR);
                r_address     <= (r_address == LAST_ADDR) ? FIRST_ADDR : r_address + ADDR_ONE;
            end else if (r_state == IDLE) begin
                r_address <= FIRST_ADDR;
            end
        end
    end

    assign w_pop = w_fifoValid && st_ready;

    pxbf_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (r_inflight),
        .i_data  ({r_inflightEop, r_inflightSop, m_readdata}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_valid (w_fifoValid),
        .o_count (w_fifoCount)
    );

    assign m_address    = r_address;
    assign m_read       = w_issue;
    assign m_chipselect = w_issue;
    assign m_byteenable = 2'b11;
    assign st_data      = w_head[DATA_W-1:0];
    assign st_valid     = w_fifoValid;
    assign st_sop       = w_fifoValid && w_head[SOP_BIT];
    assign st_eop       = w_fifoValid && w_head[EOP_BIT];
    assign frame_done   = r_frameDone;

    fifoNoOverflow: assert property (@(posedge clk) disable iff (reset)
        w_fifoCount <= CNT_W'(FIFO_DEPTH));

endmodule

// File: tb/tb_pxbf_scanout_reader.sv
// Directed bench for the scan-out reader: a 4-word frame instance for cycle-exact checks
// and a 1200-word frame instance at the top of memory for a randomised back-pressure run.
module tb_pxbf_scanout_reader;

    localparam int B_WORDS = 1200;
    localparam int B_BASE  = 32768 - B_WORDS;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic        aEnable, aReady, aCs, aRead, aValid, aSop, aEop, aDone;
    logic [14:0] aAddr;
    logic [1:0]  aBe;
    logic [15:0] aRdata, aData;

    logic        bEnable, bReady, bCs, bRead, bValid, bSop, bEop, bDone;
    logic [14:0] bAddr;
    logic [1:0]  bBe;
    logic [15:0] bRdata, bData;

    int checkCount = 0;
    int passCount  = 0;

    always #5 clk = ~clk;

    // Memory models return the word address as data, one cycle after the read.
    always @(posedge clk) if (aRead) aRdata <= {1'b0, aAddr};
    always @(posedge clk) if (bRead) bRdata <= {1'b0, bAddr};

    pxbf_scanout_reader #(
        .BASE_ADDR   (16'h10),
        .FRAME_WORDS (4),
        .FIFO_DEPTH  (8)
    ) dutA (
        .clk(clk), .reset(reset), .enable(aEnable),
        .m_address(aAddr), .m_chipselect(aCs), .m_read(aRead), .m_byteenable(aBe),
        .m_readdata(aRdata), .st_data(aData), .st_valid(aValid), .st_ready(aReady),
        .st_sop(aSop), .st_eop(aEop), .frame_done(aDone)
    );

    pxbf_scanout_reader #(
        .BASE_ADDR   (B_BASE),
        .FRAME_WORDS (B_WORDS),
        .FIFO_DEPTH  (8)
    ) dutB (
        .clk(clk), .reset(reset), .enable(bEnable),
        .m_address(bAddr), .m_chipselect(bCs), .m_read(bRead), .m_byteenable(bBe),
        .m_readdata(bRdata), .st_data(bData), .st_valid(bValid), .st_ready(bReady),
        .st_sop(bSop), .st_eop(bEop), .frame_done(bDone)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic rdy);
        aEnable = en;
        aReady  = rdy;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseReset();
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b0);
        reset = 1'b1;
        #3;
        reset = 1'b0;
    endtask

    initial begin
        int reads;
        int words;
        int frames;
        int firstCycle;
        int issued;
        int received;
        int tail;
        int cyc;

        applyStimulus(1'b0, 1'b0);
        bEnable = 1'b0;
        bReady  = 1'b0;
        stepCycle();
        stepCycle();

        $display("[TB] reset values");
        checkOutput("rst m_read", aRead, 0);
        checkOutput("rst m_chipselect", aCs, 0);
        checkOutput("rst m_address", aAddr, 32'h10);
        checkOutput("rst m_byteenable", aBe, 2'b11);
        checkOutput("rst st_valid", aValid, 0);
        checkOutput("rst st_sop", aSop, 0);
        checkOutput("rst st_eop", aEop, 0);
        checkOutput("rst frame_done", aDone, 0);
        reset = 1'b0;
        stepCycle();
        checkOutput("idle m_read", aRead, 0);

        $display("[TB] streaming with st_ready=1");
        applyStimulus(1'b1, 1'b1);
        for (int c = 1; c <= 12; c++) begin
            stepCycle();
            checkOutput("stream m_read", aRead, 1);
            checkOutput("stream m_chipselect", aCs, 1);
            checkOutput("stream m_address", aAddr, 32'h10 + (c - 1) % 4);
            checkOutput("stream st_valid", aValid, (c >= 3));
            if (c >= 3) begin
                checkOutput("stream st_data", aData, 32'h10 + (c - 3) % 4);
                checkOutput("stream sop/eop", {aSop, aEop}, {((c - 3) % 4 == 0), ((c - 3) % 4 == 3)});
            end
            checkOutput("stream frame_done", aDone, (c >= 7 && (c - 7) % 4 == 0));
        end

        $display("[TB] enable dropped mid-frame");
        pulseReset();
        applyStimulus(1'b1, 1'b1);
        for (int c = 1; c <= 16; c++) begin
            stepCycle();
            checkOutput("drop m_read", aRead, (c <= 4));
            if (c <= 4) begin
                checkOutput("drop m_address", aAddr, 32'h10 + c - 1);
            end
            checkOutput("drop st_valid", aValid, (c >= 3 && c <= 6));
            if (c >= 3 && c <= 6) begin
                checkOutput("drop st_data", aData, 32'h10 + c - 3);
                checkOutput("drop sop/eop", {aSop, aEop}, {(c == 3), (c == 6)});
            end
            checkOutput("drop frame_done", aDone, (c == 7));
            if (c == 2) aEnable = 1'b0;
        end

        $display("[TB] back-pressure from cycle 0");
        pulseReset();
        applyStimulus(1'b1, 1'b0);
        reads = 0;
        for (int c = 1; c <= 20; c++) begin
            stepCycle();
            if (aRead) reads++;
            if (c == 12) aEnable = 1'b0;
        end
        checkOutput("bp read count", reads, 8);
        checkOutput("bp stalled m_read", aRead, 0);
        checkOutput("bp head st_data", aData, 32'h10);
        checkOutput("bp head sop", aSop, 1);
        aReady = 1'b1;
        words  = 0;
        frames = 0;
        for (int i = 0; i < 60; i++) begin
            if (aValid && aReady) begin
                checkOutput("bp st_data", aData, 32'h10 + words % 4);
                checkOutput("bp sop/eop", {aSop, aEop}, {(words % 4 == 0), (words % 4 == 3)});
                words++;
            end
            if (aDone) frames++;
            stepCycle();
            if (i == 0) checkOutput("bp resume m_read", aRead, 1);
        end
        checkOutput("bp words delivered", words, 12);
        checkOutput("bp frame_done count", frames, 3);
        checkOutput("bp final m_read", aRead, 0);

        $display("[TB] reset with data buffered and a read in flight");
        pulseReset();
        applyStimulus(1'b1, 1'b0);
        for (int c = 1; c <= 4; c++) stepCycle();
        reset = 1'b1;
        #1;
        checkOutput("midrst m_read", aRead, 0);
        checkOutput("midrst m_chipselect", aCs, 0);
        checkOutput("midrst m_address", aAddr, 32'h10);
        checkOutput("midrst st_valid", aValid, 0);
        checkOutput("midrst st_sop", aSop, 0);
        checkOutput("midrst st_eop", aEop, 0);
        checkOutput("midrst frame_done", aDone, 0);
        #2;
        reset = 1'b0;
        applyStimulus(1'b1, 1'b1);
        firstCycle = 0;
        for (int c = 1; c <= 10; c++) begin
            stepCycle();
            if (aValid) begin
                firstCycle = c;
                break;
            end
        end
        checkOutput("restart latency", firstCycle, 3);
        checkOutput("restart st_data", aData, 32'h10);
        checkOutput("restart sop", aSop, 1);
        applyStimulus(1'b0, 1'b1);
        repeat (12) stepCycle();

        $display("[TB] random st_ready over three frames");
        bEnable  = 1'b1;
        issued   = 0;
        received = 0;
        frames   = 0;
        tail     = 0;
        cyc      = 0;
        while (cyc < 20000 && tail < 8) begin
            bReady = 1'($urandom_range(0, 1));
            if (bRead) begin
                checkOutput("rand m_address", {17'd0, bAddr}, B_BASE + issued % B_WORDS);
                issued++;
            end
            if (bValid && bReady) begin
                checkOutput("rand st_data", bData, B_BASE + received % B_WORDS);
                checkOutput("rand sop/eop", {bSop, bEop},
                            {(received % B_WORDS == 0), (received % B_WORDS == B_WORDS - 1)});
                received++;
            end
            if (bDone) frames++;
            if (received >= 2 * B_WORDS + 10) bEnable = 1'b0;
            if (received >= 3 * B_WORDS) tail++;
            stepCycle();
            cyc++;
        end
        checkOutput("rand words issued", issued, 3 * B_WORDS);
        checkOutput("rand words received", received, 3 * B_WORDS);
        checkOutput("rand frame_done count", frames, 3);
        checkOutput("rand idle st_valid", bValid, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
